// File: rtl/memory_access_arbiter_pkg.sv
// ============================================================================
// memory_access_arbiter_pkg: shared encodings for the memory access arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package memory_access_arbiter_pkg;

  localparam logic C_READ  = 1'b0;
  localparam logic C_WRITE = 1'b1;

  localparam logic C_ENABLE  = 1'b1;
  localparam logic C_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_DATA  = 1'b0,
    GRANT_INSTR = 1'b1
  } grant_t;

endpackage

`default_nettype wire

// File: rtl/access_watchdog.sv
// ============================================================================
// access_watchdog: cycle counter that flags the last allowed cycle of an access
// Rev 1.0
// ============================================================================
`default_nettype none

module access_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMER_WIDTH    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  // Timeout fires during the cycle whose increment would reach the limit,
  // so an access spends exactly TIMEOUT_CYCLES cycles enabled.
  localparam logic [TIMER_WIDTH-1:0] C_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMER_WIDTH-1:0] count_q;
  logic [TIMER_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + TIMER_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout = enable && (count_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/memory_access_arbiter.sv
// ============================================================================
// memory_access_arbiter: shares one memory port between fetch and data sides
// Rev 1.0
// ============================================================================
`default_nettype none

module memory_access_arbiter
  import memory_access_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMER_WIDTH    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instruction_memory_interface_enable,
  input  logic [31:0] instruction_memory_interface_address,
  input  logic [3:0]  instruction_memory_interface_frame_mask,
  output logic [31:0] instruction_memory_interface_rdata,
  output logic        instruction_memory_interface_ready,
  output logic        instruction_memory_interface_error,
  input  logic        data_memory_interface_enable,
  input  logic        data_memory_interface_state,
  input  logic [31:0] data_memory_interface_address,
  input  logic [3:0]  data_memory_interface_frame_mask,
  input  logic [31:0] data_memory_interface_wdata,
  output logic [31:0] data_memory_interface_rdata,
  output logic        data_memory_interface_ready,
  output logic        data_memory_interface_error,
  output logic        mem_request,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_frame_mask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int               C_SW    = $clog2(STARVE_LIMIT + 2);
  localparam logic [C_SW-1:0]  C_LIMIT = C_SW'(STARVE_LIMIT);

  state_t            state_q, state_d;
  grant_t            grant_q, grant_d;
  logic [C_SW-1:0]   starve_q, starve_d;
  logic              error_q, error_d;
  logic              mem_write_q, mem_write_d;
  logic [31:0]       mem_address_q, mem_address_d;
  logic [3:0]        mem_frame_mask_q, mem_frame_mask_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       instr_rdata_q, instr_rdata_d;
  logic [31:0]       data_rdata_q, data_rdata_d;
  logic              w_timeout;
  logic              w_instr_wins;

  access_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMER_WIDTH    (TIMER_WIDTH)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == ST_IDLE),
    .enable  (state_q == ST_GRANT),
    .timeout (w_timeout)
  );

  // Fetch wins when alone or once it has lost STARVE_LIMIT contested rounds.
  assign w_instr_wins = instruction_memory_interface_enable &&
                        (!data_memory_interface_enable || (starve_q == C_LIMIT));

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    starve_d         = starve_q;
    error_d          = error_q;
    mem_write_d      = mem_write_q;
    mem_address_d    = mem_address_q;
    mem_frame_mask_d = mem_frame_mask_q;
    mem_wdata_d      = mem_wdata_q;
    instr_rdata_d    = instr_rdata_q;
    data_rdata_d     = data_rdata_q;

    case (state_q)
      ST_IDLE: begin
        error_d = 1'b0;
        if (instruction_memory_interface_enable || data_memory_interface_enable) begin
          state_d = ST_GRANT;
          if (w_instr_wins) begin
            grant_d          = GRANT_INSTR;
            starve_d         = '0;
            mem_write_d      = C_READ;
            mem_address_d    = instruction_memory_interface_address;
            mem_frame_mask_d = instruction_memory_interface_frame_mask;
            mem_wdata_d      = '0;
          end else begin
            grant_d          = GRANT_DATA;
            mem_write_d      = (data_memory_interface_state == C_WRITE);
            mem_address_d    = data_memory_interface_address;
            mem_frame_mask_d = data_memory_interface_frame_mask;
            mem_wdata_d      = data_memory_interface_wdata;
            if (instruction_memory_interface_enable) begin
              starve_d = starve_q + C_SW'(1);
            end
          end
        end
      end
      ST_GRANT: begin
        if (mem_ready || w_timeout) begin
          state_d = ST_RESP;
          error_d = !mem_ready;
          if (grant_q == GRANT_INSTR) begin
            instr_rdata_d = mem_ready ? mem_rdata : '0;
          end else begin
            data_rdata_d = (mem_ready && !mem_write_q) ? mem_rdata : '0;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      grant_q          <= GRANT_DATA;
      starve_q         <= '0;
      error_q          <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_frame_mask_q <= '0;
      mem_wdata_q      <= '0;
      instr_rdata_q    <= '0;
      data_rdata_q     <= '0;
    end else begin
      state_q          <= state_d;
      grant_q          <= grant_d;
      starve_q         <= starve_d;
      error_q          <= error_d;
      mem_write_q      <= mem_write_d;
      mem_address_q    <= mem_address_d;
      mem_frame_mask_q <= mem_frame_mask_d;
      mem_wdata_q      <= mem_wdata_d;
      instr_rdata_q    <= instr_rdata_d;
      data_rdata_q     <= data_rdata_d;
    end
  end

  assign mem_request    = (state_q == ST_GRANT);
  assign mem_write      = mem_write_q;
  assign mem_address    = mem_address_q;
  assign mem_frame_mask = mem_frame_mask_q;
  assign mem_wdata      = mem_wdata_q;

  assign instruction_memory_interface_ready = (state_q == ST_RESP) && (grant_q == GRANT_INSTR);
  assign data_memory_interface_ready        = (state_q == ST_RESP) && (grant_q == GRANT_DATA);
  assign instruction_memory_interface_error = instruction_memory_interface_ready && error_q;
  assign data_memory_interface_error        = data_memory_interface_ready && error_q;
  assign instruction_memory_interface_rdata = instr_rdata_q;
  assign data_memory_interface_rdata        = data_rdata_q;

endmodule

`default_nettype wire
